// File: rtl/seq_ctrl_fsm_p.sv
// -----------------------------------------------------------------------------
// seq_ctrl_fsm_p
// Parametrised sequence controller.
//   - Arms on START, then waits for DATA to equal MATCH_VAL.
//   - Counts a programmable dwell while the match holds and pauses (HOLD) when
//     the match is lost.
//   - Completes with a DONE/ACK handshake.
//   - Synchronous clear (CLR) and abort (ABORT -> sticky ERR).
//
// Optional feature, enabled by defining the macro SEQ_TIMEOUT_EN:
//   a wait counter limits consecutive ARM/HOLD cycles to TMO; on expiry the
//   FSM enters ERR and the sticky o_tmo_flag is set. With the macro undefined
//   there is no wait counter and o_tmo_flag is tied low.
//
// Parameters
//   IN_W   width of the compare bus (i_data / i_match_val)
//   CNT_W  width of the dwell counter (i_dwell / o_cnt)
//   TMO    timeout limit in cycles, must be >= 1 (SEQ_TIMEOUT_EN only)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clr        synchronous clear to IDLE (highest priority)
//   i_start      start request, honoured in IDLE only
//   i_abort      abort request, honoured in ARM/RUN/HOLD
//   i_ack        completion acknowledge, honoured in DONE
//   i_data       observed bus
//   i_match_val  compare value
//   i_dwell      dwell length, sampled on the ARM->RUN transition
//   o_state      state code (IDLE=0 ARM=1 RUN=2 HOLD=3 DONE=4 ERR=5)
//   o_busy       1 in ARM, RUN or HOLD
//   o_done       1 in DONE
//   o_err        1 in ERR
//   o_cnt        remaining dwell count
//   o_tmo_flag   sticky timeout indicator
//
// All outputs are registered or decoded from registered state only; there is
// no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module seq_ctrl_fsm_p #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMO   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_ack,
    input  logic [IN_W-1:0]  i_data,
    input  logic [IN_W-1:0]  i_match_val,
    input  logic [CNT_W-1:0] i_dwell,
    output logic [2:0]       o_state,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tmo_flag
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArm  = 3'd1,
        StRun  = 3'd2,
        StHold = 3'd3,
        StDone = 3'd4,
        StErr  = 3'd5
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    logic             w_match;
    logic             w_abortable;
    logic             w_tmo_hit;

    assign w_match     = (i_data == i_match_val);
    assign w_abortable = (r_state == StArm) || (r_state == StRun) || (r_state == StHold);

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: CLR > ABORT > timeout > per-state rules.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;

        if (i_clr) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else if (i_abort && w_abortable) begin
            w_state_d = StErr;
        end else if (w_tmo_hit) begin
            // Timeout wins over a match arriving in the same cycle.
            w_state_d = StErr;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_state_d = StArm;
                    end
                end
                StArm: begin
                    if (w_match) begin
                        w_state_d = StRun;
                        w_cnt_d   = i_dwell;
                    end
                end
                StRun: begin
                    // The zero test comes first, so the decrement below only
                    // ever sees a non-zero count and can never wrap.
                    if (r_cnt == '0) begin
                        w_state_d = StDone;
                    end else if (!w_match) begin
                        w_state_d = StHold;
                    end else begin
                        w_cnt_d = r_cnt - CNT_W'(1);
                    end
                end
                StHold: begin
                    if (w_match) begin
                        w_state_d = StRun;
                    end
                end
                StDone: begin
                    if (i_ack) begin
                        w_state_d = StIdle;
                    end
                end
                StErr: begin
                    // Sticky: only CLR or reset leaves ERR.
                    w_state_d = StErr;
                end
                default: begin
                    // Unused codes 6/7 recover to IDLE.
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional wait-timeout
    // ------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned     WaitW    = $clog2(TMO + 1);
    // The counter holds the number of wait cycles already completed, so the
    // TMO-th consecutive wait cycle is the one that sees TMO-1.
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TMO - 1);

    logic [WaitW-1:0] r_wait;
    logic [WaitW-1:0] w_wait_d;
    logic             w_in_wait;
    logic             r_tmo_flag;
    logic             w_tmo_flag_d;

    assign w_in_wait = (r_state == StArm) || (r_state == StHold);
    assign w_tmo_hit = w_in_wait && (r_wait == WaitLast);

    always_comb begin
        w_wait_d = '0;
        // Count only while staying in a wait state; HOLD->RUN->HOLD restarts.
        if (!i_clr && w_in_wait && ((w_state_d == StArm) || (w_state_d == StHold))) begin
            w_wait_d = r_wait + WaitW'(1);
        end
    end

    always_comb begin
        w_tmo_flag_d = r_tmo_flag;
        if (i_clr) begin
            w_tmo_flag_d = 1'b0;
        end else if (w_tmo_hit && !i_abort) begin
            w_tmo_flag_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait     <= '0;
            r_tmo_flag <= 1'b0;
        end else begin
            r_wait     <= w_wait_d;
            r_tmo_flag <= w_tmo_flag_d;
        end
    end

    assign o_tmo_flag = r_tmo_flag;
`else
    logic unused_tmo;

    assign w_tmo_hit  = 1'b0;
    assign o_tmo_flag = 1'b0;
    assign unused_tmo = ^TMO;
`endif

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------------
    assign o_state = r_state;
    assign o_cnt   = r_cnt;
    assign o_busy  = (r_state == StArm) || (r_state == StRun) || (r_state == StHold);
    assign o_done  = (r_state == StDone);
    assign o_err   = (r_state == StErr);

endmodule

// File: tb/tb_seq_ctrl_fsm_p.sv
// -----------------------------------------------------------------------------
// tb_seq_ctrl_fsm_p
// Directed, self-checking bench for seq_ctrl_fsm_p. Each scenario task drives
// a short table of per-cycle inputs and compares the full output vector
// {state, busy, done, err, tmo_flag, cnt} sampled 1 time unit after the edge.
// Timeout checks follow the SEQ_TIMEOUT_EN macro.
// -----------------------------------------------------------------------------
module tb_seq_ctrl_fsm_p;

    localparam int unsigned TMO_P = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    localparam logic [7:0] MATCH = 8'hA5;

    typedef struct packed {
        logic       start;
        logic       abort;
        logic       ack;
        logic       clr;
        logic       match;
        logic [2:0] st;
        logic [7:0] cnt;
    } step_t;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_clr;
    logic       i_start;
    logic       i_abort;
    logic       i_ack;
    logic [7:0] i_data;
    logic [7:0] i_match_val;
    logic [7:0] i_dwell;
    logic [2:0] o_state;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [7:0] o_cnt;
    logic       o_tmo_flag;

    logic [14:0] obs;

    int unsigned vectors;
    int unsigned miscompares;

    seq_ctrl_fsm_p #(
        .IN_W (8),
        .CNT_W(8),
        .TMO  (TMO_P)
    ) u_dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clr),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_ack      (i_ack),
        .i_data     (i_data),
        .i_match_val(i_match_val),
        .i_dwell    (i_dwell),
        .o_state    (o_state),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_cnt      (o_cnt),
        .o_tmo_flag (o_tmo_flag)
    );

    assign obs = {o_state, o_busy, o_done, o_err, o_tmo_flag, o_cnt};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected output vector for a given state/count/flag.
    function automatic logic [14:0] exp_vec(input logic [2:0] st, input logic [7:0] cnt,
                                            input logic flag);
        logic busy;
        logic done;
        logic err;
        busy = (st == S_ARM) || (st == S_RUN) || (st == S_HOLD);
        done = (st == S_DONE);
        err  = (st == S_ERR);
        return {st, busy, done, err, flag, cnt};
    endfunction

    function automatic step_t mk(input logic start, input logic abort, input logic ack,
                                 input logic clr, input logic match, input logic [2:0] st,
                                 input logic [7:0] cnt);
        step_t s;
        s.start = start;
        s.abort = abort;
        s.ack   = ack;
        s.clr   = clr;
        s.match = match;
        s.st    = st;
        s.cnt   = cnt;
        return s;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input step_t s);
        i_start = s.start;
        i_abort = s.abort;
        i_ack   = s.ack;
        i_clr   = s.clr;
        i_data  = s.match ? MATCH : ~MATCH;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        drive(mk(N, N, N, N, N, S_IDLE, 8'd0));
        i_rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (obs !== exp_vec(S_IDLE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL reset_init: got %h want %h", obs, exp_vec(S_IDLE, 8'd0, N));
        end
        i_rst_n = 1'b1;

        i_dwell = 8'd5;
        drive(mk(Y, N, N, N, Y, S_ARM, 8'd0));
        tick();
        drive(mk(N, N, N, N, Y, S_RUN, 8'd5));
        tick();
        vectors++;
        if (obs !== exp_vec(S_RUN, 8'd5, N)) begin
            miscompares++;
            $display("FAIL reset_run5: got %h want %h", obs, exp_vec(S_RUN, 8'd5, N));
        end
        // Assert reset mid-cycle; outputs must clear before the next edge.
        #2;
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== exp_vec(S_IDLE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", obs, exp_vec(S_IDLE, 8'd0, N));
        end
        tick();
        i_rst_n = 1'b1;
        drive(mk(N, N, N, N, N, S_IDLE, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_IDLE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", obs, exp_vec(S_IDLE, 8'd0, N));
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_dwell();
        step_t q[$];
        i_dwell = 8'd3;
        q.push_back(mk(Y, N, N, N, Y, S_ARM,  8'd0));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd3));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd2));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd1));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd0));
        // ACK on the entry edge into DONE must not count.
        q.push_back(mk(N, N, Y, N, Y, S_DONE, 8'd0));
        q.push_back(mk(N, N, N, N, Y, S_DONE, 8'd0));
        q.push_back(mk(N, N, N, N, N, S_DONE, 8'd0));
        q.push_back(mk(N, N, Y, N, Y, S_IDLE, 8'd0));
        q.push_back(mk(N, N, N, N, Y, S_IDLE, 8'd0));
        foreach (q[i]) begin
            drive(q[i]);
            tick();
            vectors++;
            if (obs !== exp_vec(q[i].st, q[i].cnt, N)) begin
                miscompares++;
                $display("FAIL dwell step %0d: got %h want %h", i, obs,
                         exp_vec(q[i].st, q[i].cnt, N));
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_pause();
        step_t q[$];
        i_dwell = 8'd4;
        q.push_back(mk(Y, N, N, N, Y, S_ARM,  8'd0));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd4));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd3));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd2));
        q.push_back(mk(N, N, N, N, N, S_HOLD, 8'd2));
        q.push_back(mk(N, N, N, N, N, S_HOLD, 8'd2));
        q.push_back(mk(N, N, N, N, N, S_HOLD, 8'd2));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd2));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd1));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd0));
        q.push_back(mk(N, N, N, N, Y, S_DONE, 8'd0));
        q.push_back(mk(N, N, Y, N, Y, S_IDLE, 8'd0));
        foreach (q[i]) begin
            drive(q[i]);
            tick();
            vectors++;
            if (obs !== exp_vec(q[i].st, q[i].cnt, N)) begin
                miscompares++;
                $display("FAIL pause step %0d: got %h want %h", i, obs,
                         exp_vec(q[i].st, q[i].cnt, N));
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_abort_clear();
        step_t q[$];
        i_dwell = 8'd2;
        q.push_back(mk(Y, N, N, N, N, S_ARM,  8'd0));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd2));
        q.push_back(mk(N, N, N, N, N, S_HOLD, 8'd2));
        q.push_back(mk(N, Y, N, N, N, S_ERR,  8'd2));
        q.push_back(mk(Y, N, Y, N, N, S_ERR,  8'd2));
        q.push_back(mk(N, N, N, N, Y, S_ERR,  8'd2));
        q.push_back(mk(N, N, N, Y, Y, S_IDLE, 8'd0));
        q.push_back(mk(Y, N, N, N, Y, S_ARM,  8'd0));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd2));
        q.push_back(mk(N, Y, N, Y, Y, S_IDLE, 8'd0));
        q.push_back(mk(Y, N, N, N, N, S_ARM,  8'd0));
        q.push_back(mk(N, Y, N, N, Y, S_ERR,  8'd0));
        q.push_back(mk(N, N, N, Y, N, S_IDLE, 8'd0));
        foreach (q[i]) begin
            drive(q[i]);
            tick();
            vectors++;
            if (obs !== exp_vec(q[i].st, q[i].cnt, N)) begin
                miscompares++;
                $display("FAIL abort_clear step %0d: got %h want %h", i, obs,
                         exp_vec(q[i].st, q[i].cnt, N));
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_edges();
        step_t q[$];
        i_dwell = 8'd0;
        q.push_back(mk(Y, N, N, N, Y, S_ARM,  8'd0));
        q.push_back(mk(N, N, N, N, Y, S_RUN,  8'd0));
        q.push_back(mk(N, N, N, N, Y, S_DONE, 8'd0));
        q.push_back(mk(N, Y, N, N, Y, S_DONE, 8'd0));
        q.push_back(mk(Y, N, N, N, Y, S_DONE, 8'd0));
        q.push_back(mk(N, N, Y, N, Y, S_IDLE, 8'd0));
        foreach (q[i]) begin
            drive(q[i]);
            tick();
            vectors++;
            if (obs !== exp_vec(q[i].st, q[i].cnt, N)) begin
                miscompares++;
                $display("FAIL edges_dwell0 step %0d: got %h want %h", i, obs,
                         exp_vec(q[i].st, q[i].cnt, N));
            end
        end

        // Maximum dwell with START held high throughout RUN.
        i_dwell = 8'hFF;
        drive(mk(Y, N, N, N, Y, S_ARM, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_ARM, 8'd0, N)) begin
            miscompares++;
            $display("FAIL edges_ff_arm: got %h want %h", obs, exp_vec(S_ARM, 8'd0, N));
        end
        for (int i = 0; i < 256; i++) begin
            drive(mk(Y, N, N, N, Y, S_RUN, 8'd0));
            tick();
            vectors++;
            if (obs !== exp_vec(S_RUN, 8'(255 - i), N)) begin
                miscompares++;
                $display("FAIL edges_ff_run cycle %0d: got %h want %h", i, obs,
                         exp_vec(S_RUN, 8'(255 - i), N));
            end
        end
        drive(mk(N, N, N, N, Y, S_DONE, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_DONE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL edges_ff_done: got %h want %h", obs, exp_vec(S_DONE, 8'd0, N));
        end
        drive(mk(N, N, Y, N, Y, S_IDLE, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_IDLE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL edges_ff_idle: got %h want %h", obs, exp_vec(S_IDLE, 8'd0, N));
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_timeout();
`ifdef SEQ_TIMEOUT_EN
        // No match: 16 ARM cycles, then ERR with the flag set.
        drive(mk(Y, N, N, N, N, S_ARM, 8'd0));
        for (int k = 1; k <= 16; k++) begin
            tick();
            drive(mk(N, N, N, N, N, S_ARM, 8'd0));
            vectors++;
            if (obs !== exp_vec(S_ARM, 8'd0, N)) begin
                miscompares++;
                $display("FAIL tmo_wait cycle %0d: got %h want %h", k, obs,
                         exp_vec(S_ARM, 8'd0, N));
            end
        end
        tick();
        vectors++;
        if (obs !== exp_vec(S_ERR, 8'd0, Y)) begin
            miscompares++;
            $display("FAIL tmo_expire: got %h want %h", obs, exp_vec(S_ERR, 8'd0, Y));
        end
        drive(mk(N, N, N, Y, N, S_IDLE, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_IDLE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL tmo_clr: got %h want %h", obs, exp_vec(S_IDLE, 8'd0, N));
        end

        // Match during ARM cycle 15: RUN, no flag.
        i_dwell = 8'd2;
        drive(mk(Y, N, N, N, N, S_ARM, 8'd0));
        for (int k = 1; k <= 15; k++) begin
            tick();
            drive(mk(N, N, N, N, N, S_ARM, 8'd0));
        end
        drive(mk(N, N, N, N, Y, S_RUN, 8'd2));
        tick();
        vectors++;
        if (obs !== exp_vec(S_RUN, 8'd2, N)) begin
            miscompares++;
            $display("FAIL tmo_match15: got %h want %h", obs, exp_vec(S_RUN, 8'd2, N));
        end
        drive(mk(N, N, N, Y, N, S_IDLE, 8'd0));
        tick();

        // Match during ARM cycle 16 loses to the timeout.
        drive(mk(Y, N, N, N, N, S_ARM, 8'd0));
        for (int k = 1; k <= 16; k++) begin
            tick();
            drive(mk(N, N, N, N, N, S_ARM, 8'd0));
        end
        drive(mk(N, N, N, N, Y, S_ERR, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_ERR, 8'd0, Y)) begin
            miscompares++;
            $display("FAIL tmo_match16: got %h want %h", obs, exp_vec(S_ERR, 8'd0, Y));
        end
        drive(mk(N, N, N, Y, N, S_IDLE, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_IDLE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL tmo_clr2: got %h want %h", obs, exp_vec(S_IDLE, 8'd0, N));
        end
`else
        // Without the timeout, ARM waits indefinitely and the flag stays low.
        drive(mk(Y, N, N, N, N, S_ARM, 8'd0));
        for (int k = 1; k <= 1000; k++) begin
            tick();
            drive(mk(N, N, N, N, N, S_ARM, 8'd0));
            vectors++;
            if (obs !== exp_vec(S_ARM, 8'd0, N)) begin
                miscompares++;
                $display("FAIL no_tmo cycle %0d: got %h want %h", k, obs,
                         exp_vec(S_ARM, 8'd0, N));
            end
        end
        drive(mk(N, N, N, Y, N, S_IDLE, 8'd0));
        tick();
        vectors++;
        if (obs !== exp_vec(S_IDLE, 8'd0, N)) begin
            miscompares++;
            $display("FAIL no_tmo_clr: got %h want %h", obs, exp_vec(S_IDLE, 8'd0, N));
        end
`endif
    endtask

    // ------------------------------------------------------------------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        i_rst_n     = 1'b0;
        i_clr       = 1'b0;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_ack       = 1'b0;
        i_match_val = MATCH;
        i_data      = ~MATCH;
        i_dwell     = 8'd0;

        test_reset();
        test_dwell();
        test_pause();
        test_abort_clear();
        test_edges();
        test_timeout();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
